// File: rtl/alu_sequencer_if.sv
// Token stream and result stream between the sequencer and its producer/consumer.
//   in_data/in_valid/in_ready     : 4-bit token stream into the sequencer
//   out_data/out_zero/out_valid/out_ready : registered result stream out of the sequencer
// master = producer/consumer side, slave = sequencer side.
interface alu_sequencer_if;
  localparam int unsigned DW = 4;

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_zero;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_zero, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_zero, out_valid
  );
endinterface

// File: rtl/alu_sequencer.sv
// Operand/opcode sequencer for the 4-bit calculator ALU.
// Collects A, B and opcode tokens, drives the ALU from registers, captures the
// result into a handshaked output, and optionally chains the result into A.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clear_i        : synchronous abort (op_count preserved)
//   bus            : token in / result out streams (slave modport)
//   alu_a_o/alu_b_o/alu_sel_o : registered ALU operands and select
//   alu_result_i   : combinational ALU result
//   op_count_o     : completed operations, saturating at 255
module alu_sequencer (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  alu_sequencer_if.slave       bus,
  output logic [3:0]           alu_a_o,
  output logic [3:0]           alu_b_o,
  output logic [2:0]           alu_sel_o,
  input  logic [3:0]           alu_result_i,
  output logic [7:0]           op_count_o
);
  localparam int unsigned DW = 4;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    RESULT  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          chain_q, chain_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_zero_q, out_zero_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] op_count_q, op_count_d;
  logic          in_ready_c;
  logic          accept_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_A;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      chain_q     <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b1;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      chain_q     <= chain_d;
      out_data_q  <= out_data_d;
      out_zero_q  <= out_zero_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    chain_d     = chain_q;
    out_data_d  = out_data_q;
    out_zero_d  = out_zero_q;
    out_valid_d = out_valid_q;
    op_count_d  = op_count_q;

    // Ready depends only on state and rst, never on in_valid
    in_ready_c = !rst && (state_q == WAIT_A || state_q == WAIT_B || state_q == WAIT_OP);
    // A token coinciding with clear is dropped
    accept_c   = bus.in_valid && in_ready_c && !clear_i;

    case (state_q)
      WAIT_A: begin
        if (accept_c) begin
          a_d     = bus.in_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (accept_c) begin
          b_d     = bus.in_data;
          state_d = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (accept_c) begin
          sel_d   = bus.in_data[SW-1:0];
          chain_d = bus.in_data[DW-1];
          state_d = EXEC;
        end
      end
      EXEC: begin
        out_data_d  = alu_result_i;
        out_zero_d  = (alu_result_i == '0);
        out_valid_d = 1'b1;
        if (op_count_q != {CW{1'b1}}) begin
          op_count_d = op_count_q + CW'(1);
        end
        state_d = RESULT;
      end
      RESULT: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (chain_q) begin
            a_d     = out_data_q;
            state_d = WAIT_B;
          end else begin
            state_d = WAIT_A;
          end
        end
      end
      default: state_d = WAIT_A;
    endcase

    // Abort: everything back to reset values except the operation counter
    if (clear_i) begin
      state_d     = WAIT_A;
      a_d         = '0;
      b_d         = '0;
      sel_d       = '0;
      chain_d     = 1'b0;
      out_data_d  = '0;
      out_zero_d  = 1'b1;
      out_valid_d = 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_valid = out_valid_q;
  assign alu_a_o       = a_q;
  assign alu_b_o       = b_q;
  assign alu_sel_o     = sel_q;
  assign op_count_o    = op_count_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_sequencer;
  logic       clk;
  logic       rst;
  logic       clear;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_sel;
  logic [7:0] op_count;

  int n_checks = 0;
  int n_fails  = 0;
  int exp_cnt  = 0;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear),
    .bus          (bus.slave),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_sel_o    (alu_sel),
    .alu_result_i (alu_result),
    .op_count_o   (op_count)
  );

  // Downstream ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 A, 7 B
  always_comb begin
    case (alu_sel)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = alu_a ^ alu_b;
      3'd5:    alu_result = ~alu_a;
      3'd6:    alu_result = alu_a;
      default: alu_result = alu_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [3:0] res;
    logic       z;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Offer a token and hold it until accepted (bounded)
  task automatic send(input logic [3:0] tok);
    int n = 0;
    bus.in_data  = tok;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fails++;
      $display("FAIL send_timeout: token 0x%0h got no in_ready, required in_ready=1", tok);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic bump_cnt();
    if (exp_cnt != 255) exp_cnt++;
  endtask

  // Full non-chained operation with out_ready held high
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                        input logic [3:0] res, input logic z);
    bus.out_ready = 1'b1;
    send(a);
    send(b);
    send(op);
    check("exec_alu_a", 8'(alu_a), 8'(a));
    check("exec_alu_b", 8'(alu_b), 8'(b));
    check("exec_alu_sel", 8'(alu_sel), 8'(op[2:0]));
    check("exec_out_valid_low", 8'(bus.out_valid), 8'd0);
    @(posedge clk); #1;
    bump_cnt();
    check("res_out_valid", 8'(bus.out_valid), 8'd1);
    check("res_out_data", 8'(bus.out_data), 8'(res));
    check("res_out_zero", 8'(bus.out_zero), 8'(z));
    check("res_op_count", op_count, 8'(exp_cnt));
    @(posedge clk); #1;
    check("post_out_valid_low", 8'(bus.out_valid), 8'd0);
    check("post_in_ready", 8'(bus.in_ready), 8'd1);
  endtask

  initial begin
    vecs[0] = '{a: 4'h9, b: 4'h8, op: 4'h0, res: 4'h1, z: 1'b0}; // ADD overflow
    vecs[1] = '{a: 4'h5, b: 4'h3, op: 4'h1, res: 4'h2, z: 1'b0}; // SUB
    vecs[2] = '{a: 4'h3, b: 4'h3, op: 4'h1, res: 4'h0, z: 1'b1}; // SUB to zero
    vecs[3] = '{a: 4'hC, b: 4'hA, op: 4'h2, res: 4'h8, z: 1'b0}; // AND
    vecs[4] = '{a: 4'hC, b: 4'hA, op: 4'h3, res: 4'hE, z: 1'b0}; // OR
    vecs[5] = '{a: 4'h1, b: 4'h1, op: 4'h4, res: 4'h0, z: 1'b1}; // XOR
    vecs[6] = '{a: 4'h6, b: 4'h2, op: 4'h5, res: 4'h9, z: 1'b0}; // NOT A
    vecs[7] = '{a: 4'h0, b: 4'h1, op: 4'h1, res: 4'hF, z: 1'b0}; // SUB borrow wrap

    rst           = 1'b1;
    clear         = 1'b0;
    bus.in_data   = 4'h0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 8'(bus.out_valid), 8'd0);
    check("rst_out_zero", 8'(bus.out_zero), 8'd1);
    check("rst_op_count", op_count, 8'd0);
    check("rst_in_ready", 8'(bus.in_ready), 8'd0);
    check("rst_alu_a", 8'(alu_a), 8'd0);
    check("rst_out_data", 8'(bus.out_data), 8'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 8'(bus.in_ready), 8'd1);

    // Table-driven single operations
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].z);
    end

    // Chain: 5 - 3 = 2, then 2 - 2 = 0 without a new A token
    bus.out_ready = 1'b1;
    send(4'h5);
    send(4'h3);
    send(4'h9);
    check("chain_exec_sel", 8'(alu_sel), 8'd1);
    @(posedge clk); #1;
    bump_cnt();
    check("chain1_out_data", 8'(bus.out_data), 8'h2);
    check("chain1_out_valid", 8'(bus.out_valid), 8'd1);
    @(posedge clk); #1;
    check("chain_load_alu_a", 8'(alu_a), 8'h2);
    check("chain_in_ready", 8'(bus.in_ready), 8'd1);
    send(4'h2);
    send(4'h1);
    check("chain2_exec_alu_a", 8'(alu_a), 8'h2);
    check("chain2_exec_alu_b", 8'(alu_b), 8'h2);
    @(posedge clk); #1;
    bump_cnt();
    check("chain2_out_data", 8'(bus.out_data), 8'h0);
    check("chain2_out_zero", 8'(bus.out_zero), 8'd1);
    check("chain2_op_count", op_count, 8'(exp_cnt));
    @(posedge clk); #1;
    check("chain2_done_valid", 8'(bus.out_valid), 8'd0);

    // Backpressure with a pending token during RESULT
    bus.out_ready = 1'b0;
    send(4'hC);
    send(4'hA);
    send(4'h2);
    bus.in_data  = 4'h7;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bump_cnt();
    check("bp_out_valid", 8'(bus.out_valid), 8'd1);
    check("bp_out_data", 8'(bus.out_data), 8'h8);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 8'(bus.out_valid), 8'd1);
      check("bp_hold_data", 8'(bus.out_data), 8'h8);
      check("bp_hold_in_ready", 8'(bus.in_ready), 8'd0);
      check("bp_hold_alu_a", 8'(alu_a), 8'hC);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 8'(bus.out_valid), 8'd0);
    check("bp_release_in_ready", 8'(bus.in_ready), 8'd1);
    check("bp_release_alu_a", 8'(alu_a), 8'hC);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_pending_as_a", 8'(alu_a), 8'h7);
    send(4'h1);
    send(4'h0);
    @(posedge clk); #1;
    bump_cnt();
    check("bp_next_out_data", 8'(bus.out_data), 8'h8);
    @(posedge clk); #1;

    // Clear coincident with the opcode token
    send(4'h3);
    send(4'h4);
    bus.in_data  = 4'h0;
    bus.in_valid = 1'b1;
    clear        = 1'b1;
    @(posedge clk); #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_in_ready", 8'(bus.in_ready), 8'd1);
    check("clr_alu_a", 8'(alu_a), 8'd0);
    check("clr_alu_b", 8'(alu_b), 8'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("clr_no_result", 8'(bus.out_valid), 8'd0);
    end
    check("clr_op_count_kept", op_count, 8'(exp_cnt));
    run_op(4'h1, 4'h1, 4'h4, 4'h0, 1'b1);

    // Saturation of the operation counter
    for (int k = 0; k < 256; k++) begin
      bus.out_ready = 1'b1;
      send(4'h0);
      send(4'h0);
      send(4'h5);
      @(posedge clk); #1;
      bump_cnt();
      check("sat_out_data", 8'(bus.out_data), 8'hF);
      check("sat_op_count", op_count, 8'(exp_cnt));
      @(posedge clk); #1;
    end
    check("sat_final", op_count, 8'd255);

    // rst and clear together: rst wins, counter cleared
    rst   = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    clear = 1'b0;
    #1;
    check("rst_clr_op_count", op_count, 8'd0);
    check("rst_clr_in_ready", 8'(bus.in_ready), 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
